// File: rtl/clk_reset_pkg.sv
// rtl/clk_reset_pkg.sv - shared state encoding, counter widths and tolerance helper
package clk_reset_pkg;

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, RELEASE, RUN} state_t;

    localparam int EDGE_W = 16;

    // Bits needed for a counter that runs 0..n-1.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // |cnt - expected| > tol, evaluated in EDGE_W+1-bit signed arithmetic.
    function automatic logic out_of_tol(input logic [EDGE_W-1:0] cnt,
                                        input int expected, input int tol);
        logic signed [EDGE_W:0] dev;
        logic signed [EDGE_W:0] mag;
        dev = $signed({1'b0, cnt}) - (EDGE_W+1)'(expected);
        mag = dev[EDGE_W] ? -dev : dev;
        return mag > (EDGE_W+1)'(tol);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_reset_seq.sv
// rtl/clk_reset_seq.sv - lock-qualified staged reset release plus monitored-clock frequency check
module clk_reset_seq
    import clk_reset_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP          = 16,
    parameter int NUM_STAGES         = 3,
    parameter int WIN_CYCLES         = 4096,
    parameter int EXP_EDGES          = 1638,
    parameter int TOL                = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pll_locked,
    input  logic                  mon_toggle,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  all_ready,
    output logic [7:0]            lock_loss_cnt,
    output logic [15:0]           freq_count,
    output logic                  freq_valid,
    output logic                  freq_err
);

    localparam int STAB_W = cnt_w(LOCK_STABLE_CYCLES);
    localparam int GAP_W  = cnt_w(STAGE_GAP);
    localparam int WIN_W  = cnt_w(WIN_CYCLES);

    logic lock_s;
    logic tog_s;

    sync_2ff u_sync_lock (.clk(clk), .reset(reset), .d(pll_locked), .q(lock_s));
    sync_2ff u_sync_tog  (.clk(clk), .reset(reset), .d(mon_toggle), .q(tog_s));

    state_t             state;
    logic [STAB_W-1:0]  stable_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    // rst_out is all ones outside RELEASE/RUN, so a left shift always frees the next stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT_LOCK;
            rst_out       <= '1;
            all_ready     <= 1'b0;
            lock_loss_cnt <= '0;
            stable_cnt    <= '0;
            gap_cnt       <= '0;
        end else if (state != WAIT_LOCK && !lock_s) begin
            state      <= WAIT_LOCK;
            rst_out    <= '1;
            all_ready  <= 1'b0;
            stable_cnt <= '0;
            gap_cnt    <= '0;
            if (lock_loss_cnt != 8'hFF)
                lock_loss_cnt <= lock_loss_cnt + 8'd1;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    rst_out   <= '1;
                    all_ready <= 1'b0;
                    gap_cnt   <= '0;
                    if (lock_s) begin
                        if (LOCK_STABLE_CYCLES <= 1) begin
                            state   <= RELEASE;
                            rst_out <= rst_out << 1;
                        end else begin
                            state      <= STABLE;
                            stable_cnt <= STAB_W'(1);
                        end
                    end
                end
                STABLE: begin
                    if (stable_cnt == STAB_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state   <= RELEASE;
                        rst_out <= rst_out << 1;
                        gap_cnt <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + STAB_W'(1);
                    end
                end
                RELEASE: begin
                    if (rst_out == '0) begin
                        state     <= RUN;
                        all_ready <= 1'b1;
                    end else if (gap_cnt == GAP_W'(STAGE_GAP - 1)) begin
                        rst_out <= rst_out << 1;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                RUN: begin
                    rst_out   <= '0;
                    all_ready <= 1'b1;
                end
                default: begin
                    state   <= WAIT_LOCK;
                    rst_out <= '1;
                end
            endcase
        end
    end

    logic              tog_prev;
    logic [WIN_W-1:0]  win_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [EDGE_W-1:0] edge_next;

    always_comb begin
        edge_next = edge_cnt;
        if ((tog_s ^ tog_prev) && edge_cnt != '1)
            edge_next = edge_cnt + EDGE_W'(1);
    end

    // The window's final cycle contributes its own edge before the count is published.
    always_ff @(posedge clk) begin
        if (reset) begin
            tog_prev   <= 1'b0;
            win_cnt    <= '0;
            edge_cnt   <= '0;
            freq_count <= '0;
            freq_valid <= 1'b0;
            freq_err   <= 1'b0;
        end else begin
            tog_prev <= tog_s;
            if (win_cnt == WIN_W'(WIN_CYCLES - 1)) begin
                win_cnt    <= '0;
                edge_cnt   <= '0;
                freq_count <= edge_next;
                freq_valid <= 1'b1;
                freq_err   <= out_of_tol(edge_next, EXP_EDGES, TOL);
            end else begin
                win_cnt    <= win_cnt + WIN_W'(1);
                edge_cnt   <= edge_next;
                freq_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_reset_seq.sv
// tb/tb_clk_reset_seq.sv - directed self-checking bench for clk_reset_seq
module tb_clk_reset_seq;

    logic       clk;
    logic       reset;
    logic       pll_locked;
    logic       mon_toggle;
    logic [2:0] rst_out;
    logic       all_ready;
    logic [7:0] lock_loss_cnt;
    logic [15:0] freq_count;
    logic       freq_valid;
    logic       freq_err;

    int n_tests = 0;
    int n_fail  = 0;

    clk_reset_seq #(
        .LOCK_STABLE_CYCLES(8),
        .STAGE_GAP(4),
        .NUM_STAGES(3),
        .WIN_CYCLES(64),
        .EXP_EDGES(20),
        .TOL(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pll_locked(pll_locked),
        .mon_toggle(mon_toggle),
        .rst_out(rst_out),
        .all_ready(all_ready),
        .lock_loss_cnt(lock_loss_cnt),
        .freq_count(freq_count),
        .freq_valid(freq_valid),
        .freq_err(freq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Toggles n times on even cycles of a 64-cycle window, then checks the published result.
    task automatic run_window(input int n, input int exp_cnt, input logic exp_err);
        for (int j = 0; j < 64; j++) begin
            if (j % 2 == 0 && j / 2 < n)
                mon_toggle = ~mon_toggle;
            tick(1);
            if (j == 1)
                chk($sformatf("valid_low_mid_%0d", n), 32'(freq_valid), 32'd0);
        end
        chk($sformatf("valid_pulse_%0d", n), 32'(freq_valid), 32'd1);
        chk($sformatf("freq_count_%0d", n), 32'(freq_count), 32'(exp_cnt));
        chk($sformatf("freq_err_%0d", n), 32'(freq_err), 32'(exp_err));
    endtask

    task automatic lock_loss_event();
        pll_locked = 1'b1;
        tick(3);
        pll_locked = 1'b0;
        tick(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        pll_locked = 1'b0;
        mon_toggle = 1'b0;
        tick(3);
        chk("rst_rst_out", 32'(rst_out), 32'h7);
        chk("rst_all_ready", 32'(all_ready), 32'd0);
        chk("rst_loss_cnt", 32'(lock_loss_cnt), 32'd0);
        chk("rst_freq_count", 32'(freq_count), 32'd0);
        chk("rst_freq_valid", 32'(freq_valid), 32'd0);
        chk("rst_freq_err", 32'(freq_err), 32'd0);
        reset = 1'b0;

        // Clean lock-up: lock_s rises 2 edges after the drive, stage 0 frees 8 edges after that.
        pll_locked = 1'b1;
        tick(9);
        chk("lockup_before_s0", 32'(rst_out), 32'h7);
        tick(1);
        chk("lockup_s0", 32'(rst_out), 32'h6);
        tick(3);
        chk("lockup_before_s1", 32'(rst_out), 32'h6);
        tick(1);
        chk("lockup_s1", 32'(rst_out), 32'h4);
        tick(4);
        chk("lockup_s2", 32'(rst_out), 32'h0);
        chk("lockup_ready_late", 32'(all_ready), 32'd0);
        tick(1);
        chk("lockup_ready", 32'(all_ready), 32'd1);

        tick(70);
        chk("idle_freq_count", 32'(freq_count), 32'd0);
        chk("idle_freq_err", 32'(freq_err), 32'd1);

        // Loss in RUN: effect appears 3 edges after the drive.
        pll_locked = 1'b0;
        tick(2);
        chk("runloss_hold_rst", 32'(rst_out), 32'h0);
        chk("runloss_hold_ready", 32'(all_ready), 32'd1);
        tick(1);
        chk("runloss_rst", 32'(rst_out), 32'h7);
        chk("runloss_ready", 32'(all_ready), 32'd0);
        chk("runloss_cnt", 32'(lock_loss_cnt), 32'd1);

        // Glitch in STABLE four cycles after lock_s rises.
        pll_locked = 1'b1;
        tick(6);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        chk("glitch_cnt", 32'(lock_loss_cnt), 32'd2);
        chk("glitch_rst", 32'(rst_out), 32'h7);
        tick(1);
        chk("glitch_no_early_release", 32'(rst_out), 32'h7);
        tick(6);
        chk("glitch_before_s0", 32'(rst_out), 32'h7);
        tick(1);
        chk("glitch_s0", 32'(rst_out), 32'h6);
        tick(4);
        chk("glitch_s1", 32'(rst_out), 32'h4);

        // Reset pulse in RELEASE.
        reset = 1'b1;
        tick(1);
        chk("midrst_rst_out", 32'(rst_out), 32'h7);
        chk("midrst_ready", 32'(all_ready), 32'd0);
        chk("midrst_loss_cnt", 32'(lock_loss_cnt), 32'd0);
        chk("midrst_freq_count", 32'(freq_count), 32'd0);
        chk("midrst_freq_valid", 32'(freq_valid), 32'd0);
        chk("midrst_freq_err", 32'(freq_err), 32'd0);
        reset = 1'b0;

        run_window(20, 20, 1'b0);
        run_window(23, 23, 1'b1);
        run_window(18, 18, 1'b0);
        run_window(22, 22, 1'b0);
        run_window(17, 17, 1'b1);

        reset      = 1'b1;
        pll_locked = 1'b0;
        tick(1);
        reset = 1'b0;
        for (int e = 0; e < 254; e++)
            lock_loss_event();
        chk("sat_254", 32'(lock_loss_cnt), 32'd254);
        lock_loss_event();
        chk("sat_255", 32'(lock_loss_cnt), 32'd255);
        for (int e = 0; e < 45; e++)
            lock_loss_event();
        chk("sat_hold_255", 32'(lock_loss_cnt), 32'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
